// File: rtl/branch_pc_unit.sv
// branch_pc_unit
//   Execute-stage branch resolution and PC ownership for the 3-stage core.
//   Decodes the branch condition from funct3 and the comparator flags,
//   drives BrUn back to the comparator, holds the fetch PC and issues the
//   fetch-stage kill whenever execute redirects the PC.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   stall         hold PC/state; no redirect this cycle
//   ex_valid      execute instruction is live
//   br_valid      execute instruction is a conditional branch
//   jump          execute instruction is JAL/JALR
//   br_funct3     branch funct3
//   BrEq, BrLt    comparator flags
//   target        ALU-computed branch/jump target
//   BrUn          to comparator: 1 = unsigned compare
//   pc_if         registered fetch PC
//   if_valid      registered fetch-valid
//   pc_sel        redirect taken this cycle (combinational)
//   kill_if       squash fetch instruction (same as pc_sel)
//   br_illegal    one-cycle pulse: funct3 010/011 on a live branch
//   misalign      one-cycle pulse: redirect target bit1 set
//
// Optional: define BRANCH_PERF_EN to add perf_br / perf_taken counters.

module branch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic        br_valid,
   input  logic        jump,
   input  logic [2:0]  br_funct3,
   input  logic        BrEq,
   input  logic        BrLt,
   input  logic [31:0] target,
   output logic        BrUn,
   output logic [31:0] pc_if,
   output logic        if_valid,
   output logic        pc_sel,
   output logic        kill_if,
   output logic        br_illegal,
`ifdef BRANCH_PERF_EN
   output logic [31:0] perf_br,
   output logic [31:0] perf_taken,
`endif
   output logic        misalign
);

   typedef enum logic {BOOT, RUN} state_t;

   state_t      state;
   logic        cond;
   logic        legal;
   logic        want;
   logic        run_go;
   logic [31:0] tgt;

   // BrUn must be valid in the same cycle the comparator evaluates,
   // so it comes straight from funct3 with no qualification.
   assign BrUn = br_funct3[1];

   always_comb begin
      cond  = 1'b0;
      legal = 1'b1;
      case (br_funct3)
         3'b000:  cond = BrEq;
         3'b001:  cond = !BrEq;
         3'b100:  cond = BrLt;
         3'b101:  cond = !BrLt;
         3'b110:  cond = BrLt;
         3'b111:  cond = !BrLt;
         default: begin
            cond  = 1'b0;
            legal = 1'b0;
         end
      endcase
   end

   // JALR semantics: bit0 of the target is always dropped.
   assign tgt    = target & ~32'h1;
   assign want   = ex_valid & ((br_valid & cond) | jump);
   assign run_go = (state == RUN) & !stall;
   // A target with bit1 set is not a legal fetch address; the redirect is
   // suppressed and the core traps on the misalign pulse instead.
   assign pc_sel  = want & run_go & !tgt[1];
   assign kill_if = pc_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         pc_if      <= RESET_PC;
         if_valid   <= 1'b0;
         br_illegal <= 1'b0;
         misalign   <= 1'b0;
      end else begin
         br_illegal <= 1'b0;
         misalign   <= 1'b0;
         case (state)
            BOOT: begin
               // First fetch uses RESET_PC itself, so the PC is not bumped here.
               state    <= RUN;
               if_valid <= 1'b1;
            end
            RUN: begin
               if (!stall) begin
                  if_valid   <= 1'b1;
                  pc_if      <= pc_sel ? tgt : pc_if + 32'd4;
                  br_illegal <= ex_valid & br_valid & !jump & !legal;
                  misalign   <= want & tgt[1];
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

`ifdef BRANCH_PERF_EN
   logic br_count;
   assign br_count = run_go & ex_valid & br_valid & !jump & legal;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_br    <= 32'd0;
         perf_taken <= 32'd0;
      end else if (br_count) begin
         perf_br <= perf_br + 32'd1;
         if (cond && !tgt[1])
            perf_taken <= perf_taken + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst, stall, ex_valid, br_valid, jump, BrEq, BrLt;
   logic [2:0]  br_funct3;
   logic [31:0] target;
   logic        BrUn, if_valid, pc_sel, kill_if, br_illegal, misalign;
   logic [31:0] pc_if;
`ifdef BRANCH_PERF_EN
   logic [31:0] perf_br, perf_taken;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   branch_pc_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
      .br_valid(br_valid), .jump(jump), .br_funct3(br_funct3),
      .BrEq(BrEq), .BrLt(BrLt), .target(target), .BrUn(BrUn),
      .pc_if(pc_if), .if_valid(if_valid), .pc_sel(pc_sel), .kill_if(kill_if),
      .br_illegal(br_illegal),
`ifdef BRANCH_PERF_EN
      .perf_br(perf_br), .perf_taken(perf_taken),
`endif
      .misalign(misalign)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Behaves as the comparator: flags derived from actual operands and the
   // signedness implied by funct3[1].
   task automatic drive(input logic st, input logic ev, input logic bv, input logic jp,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] tg);
      stall = st; ex_valid = ev; br_valid = bv; jump = jp; br_funct3 = f3;
      target = tg;
      BrEq = (a == b);
      BrLt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
   endtask

   // Branch outcome from the ISA mnemonic semantics on the operands.
   function automatic logic taken_isa(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) <  $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a <  b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   typedef struct {
      logic        st, ev, bv, jp;
      logic [2:0]  f3;
      logic [31:0] a, b, tg;
      logic        sel, brun;
      logic [31:0] pc;
      logic        ill, mis;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic ev, input logic bv, input logic jp,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] tg, input logic sel, input logic brun,
                               input logic [31:0] pc, input logic ill, input logic mis);
      vec_t v;
      v.st = st; v.ev = ev; v.bv = bv; v.jp = jp; v.f3 = f3; v.a = a; v.b = b; v.tg = tg;
      v.sel = sel; v.brun = brun; v.pc = pc; v.ill = ill; v.mis = mis;
      return v;
   endfunction

   vec_t vt[$];

   // random-phase model state
   logic        m_boot, m_ifv, m_ill, m_mis;
   logic [31:0] m_pc, m_br, m_tk;

   initial begin
      drive(0, 0, 0, 0, 3'b000, 0, 0, 0);
      rst = 1'b1;

      // ---------------- reset / boot ----------------
      @(posedge clk); #1;
      chk("rst_pc", pc_if, RPC);
      chk("rst_ifv", {31'd0, if_valid}, 0);
      chk("rst_ill", {31'd0, br_illegal}, 0);
      chk("rst_mis", {31'd0, misalign}, 0);
      chk("boot_sel", {31'd0, pc_sel}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("boot_pc", pc_if, RPC);
      chk("boot_ifv", {31'd0, if_valid}, 1);
      @(posedge clk); #1;
      chk("pc_104", pc_if, 32'h104);
      @(posedge clk); #1;
      chk("pc_108", pc_if, 32'h108);

      // ---------------- directed table ----------------
      //             st ev bv jp f3      a            b        tg           sel brun pc           ill mis
      vt.push_back(mk(0,1,1,0,3'b000, 7,           7,        32'h40,        1, 0, 32'h40,        0, 0)); // BEQ taken
      vt.push_back(mk(0,0,0,0,3'b000, 0,           0,        0,             0, 0, 32'h44,        0, 0));
      vt.push_back(mk(0,1,1,0,3'b110, 5,           3,        32'h900,       0, 1, 32'h48,        0, 0)); // BLTU not taken
      vt.push_back(mk(0,1,1,0,3'b100, 5,           3,        32'h900,       0, 0, 32'h4C,        0, 0)); // BLT same operands
      vt.push_back(mk(1,1,0,1,3'b000, 0,           0,        32'h201,       0, 0, 32'h4C,        0, 0)); // JALR stalled
      vt.push_back(mk(1,1,0,1,3'b000, 0,           0,        32'h201,       0, 0, 32'h4C,        0, 0));
      vt.push_back(mk(0,1,0,1,3'b000, 0,           0,        32'h201,       1, 0, 32'h200,       0, 0)); // released
      vt.push_back(mk(0,1,1,0,3'b010, 0,           0,        32'h800,       0, 1, 32'h204,       1, 0)); // illegal funct3
      vt.push_back(mk(0,0,0,0,3'b000, 0,           0,        0,             0, 0, 32'h208,       0, 0));
      vt.push_back(mk(0,1,0,1,3'b000, 0,           0,        32'h302,       0, 0, 32'h20C,       0, 1)); // misaligned jump
      vt.push_back(mk(0,0,0,0,3'b000, 0,           0,        0,             0, 0, 32'h210,       0, 0));
      vt.push_back(mk(0,0,1,1,3'b011, 1,           1,        32'h500,       0, 1, 32'h214,       0, 0)); // ex_valid=0 masks all
      vt.push_back(mk(0,1,1,1,3'b000, 1,           2,        32'h600,       1, 0, 32'h600,       0, 0)); // jump wins over cond
      vt.push_back(mk(0,1,1,0,3'b111, 3,           5,        32'h900,       0, 1, 32'h604,       0, 0)); // BGEU not taken
      vt.push_back(mk(0,1,1,0,3'b101, 32'hFFFF_FFFF, 1,      32'h900,       0, 0, 32'h608,       0, 0)); // BGE -1>=1 false
      vt.push_back(mk(0,1,1,0,3'b111, 32'hFFFF_FFFF, 1,      32'h700,       1, 1, 32'h700,       0, 0)); // BGEU taken
      vt.push_back(mk(1,1,1,0,3'b011, 0,           0,        32'h900,       0, 1, 32'h700,       0, 0)); // stall hides illegal
      vt.push_back(mk(1,1,0,1,3'b000, 0,           0,        32'h302,       0, 0, 32'h700,       0, 0)); // stall hides misalign
      vt.push_back(mk(0,1,0,1,3'b000, 0,           0,        32'hFFFF_FFF9, 1, 0, 32'hFFFF_FFF8, 0, 0)); // bit0 dropped
      vt.push_back(mk(0,0,0,0,3'b000, 0,           0,        0,             0, 0, 32'hFFFF_FFFC, 0, 0));
      vt.push_back(mk(0,0,0,0,3'b000, 0,           0,        0,             0, 0, 32'h0,         0, 0)); // wrap

      foreach (vt[i]) begin
         drive(vt[i].st, vt[i].ev, vt[i].bv, vt[i].jp, vt[i].f3, vt[i].a, vt[i].b, vt[i].tg);
         #2;
         chk($sformatf("v%0d_brun", i), {31'd0, BrUn},    {31'd0, vt[i].brun});
         chk($sformatf("v%0d_sel", i),  {31'd0, pc_sel},  {31'd0, vt[i].sel});
         chk($sformatf("v%0d_kill", i), {31'd0, kill_if}, {31'd0, vt[i].sel});
         @(posedge clk); #1;
         chk($sformatf("v%0d_pc", i),   pc_if, vt[i].pc);
         chk($sformatf("v%0d_ifv", i),  {31'd0, if_valid},   32'd1);
         chk($sformatf("v%0d_ill", i),  {31'd0, br_illegal}, {31'd0, vt[i].ill});
         chk($sformatf("v%0d_mis", i),  {31'd0, misalign},   {31'd0, vt[i].mis});
      end

      // ---------------- reset during stall ----------------
      drive(1, 1, 0, 1, 3'b000, 0, 0, 32'h40);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midstall_rst_pc", pc_if, RPC);
      chk("midstall_rst_ifv", {31'd0, if_valid}, 0);
      rst = 1'b0;

      // ---------------- randomized vs reference model ----------------
      m_boot = 1; m_pc = RPC; m_ifv = 0; m_ill = 0; m_mis = 0; m_br = 0; m_tk = 0;
      for (int c = 0; c < 3000; c++) begin
         logic r, st, ev, bv, jp, tk, mis_now, redir, legal;
         logic [2:0]  f3;
         logic [31:0] a, b, tg, t;
         r  = ($urandom_range(0, 99) == 0);
         st = ($urandom_range(0, 4) == 0);
         ev = ($urandom_range(0, 5) != 0);
         bv = $urandom_range(0, 1);
         jp = ($urandom_range(0, 4) == 0);
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : a + 32'($urandom_range(0, 3)) - 32'd2);
         tg = $urandom;
         drive(st, ev, bv, jp, f3, a, b, tg);
         rst = r;

         legal   = (f3 != 3'b010) && (f3 != 3'b011);
         tk      = ev && (jp || (bv && taken_isa(f3, a, b)));
         t       = {tg[31:1], 1'b0};
         mis_now = tk && t[1];
         redir   = tk && !mis_now;
         #2;
         chk("rnd_brun", {31'd0, BrUn}, {31'd0, f3 >= 3'd6 || f3 == 3'd2 || f3 == 3'd3});
         chk("rnd_sel", {31'd0, pc_sel}, {31'd0, !m_boot && !st && redir});
         @(posedge clk); #1;
         if (r) begin
            m_boot = 1; m_pc = RPC; m_ifv = 0; m_ill = 0; m_mis = 0; m_br = 0; m_tk = 0;
         end else if (m_boot) begin
            m_boot = 0; m_ifv = 1; m_ill = 0; m_mis = 0;
         end else if (st) begin
            m_ill = 0; m_mis = 0;
         end else begin
            m_ill = ev && bv && !jp && !legal;
            m_mis = mis_now;
            m_pc  = redir ? t : m_pc + 4;
            if (ev && bv && !jp && legal) begin
               m_br++;
               if (taken_isa(f3, a, b) && !t[1]) m_tk++;
            end
         end
         chk("rnd_pc", pc_if, m_pc);
         chk("rnd_ifv", {31'd0, if_valid}, {31'd0, m_ifv});
         chk("rnd_ill", {31'd0, br_illegal}, {31'd0, m_ill});
         chk("rnd_mis", {31'd0, misalign}, {31'd0, m_mis});
`ifdef BRANCH_PERF_EN
         chk("rnd_perf_br", perf_br, m_br);
         chk("rnd_perf_taken", perf_taken, m_tk);
`endif
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
